// File: rtl/fpu_serial_host_if.sv
// Bundles the parallel host side and the FPU serial side of fpu_serial_host.
// The slave modport is the link itself. The master modport is whoever drives
// the operands and plays the FPU.
interface fpu_serial_host_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             op_a_ser;
  logic             op_b_ser;
  logic             frame;
  logic             res_ser;
  logic [2:0]       res_status;
  logic [WIDTH-1:0] result;
  logic [2:0]       status;
  logic             done;

  modport master (
    output start, op_a, op_b, res_ser, res_status,
    input  ready, op_a_ser, op_b_ser, frame, result, status, done
  );

  modport slave (
    input  start, op_a, op_b, res_ser, res_status,
    output ready, op_a_ser, op_b_ser, frame, result, status, done
  );
endinterface

// File: rtl/fpu_serial_host.sv
// Bit-serial host link for the FPU.
// The link latches two operands and shifts them out MSB-first. It then idles
// for RESP_DELAY cycles, shifts the serial result back in, and pulses done
// once the full word and its status are captured.
module fpu_serial_host #(
  parameter int WIDTH      = 32,
  parameter int RESP_DELAY = 4
) (
  input  logic               clock,
  input  logic               reset,
  fpu_serial_host_if.slave   bus
);

  localparam int CNT_MAX = (WIDTH > RESP_DELAY) ? WIDTH : RESP_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((RESP_DELAY > 0) ? RESP_DELAY - 1 : 0);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  // The last received bit goes straight into result, so only WIDTH-1 bits need staging.
  logic [WIDTH-2:0] rx_q, rx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       status_q, status_d;

  // State register; reset aborts any transaction and clears the captured result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_a_q <= '0;
      shift_b_q <= '0;
      rx_q      <= '0;
      result_q  <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      rx_q      <= rx_d;
      result_q  <= result_d;
      status_q  <= status_d;
    end
  end

  // Next-state logic. A single counter is reused for operand bits, delay cycles and result bits.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    rx_d      = rx_q;
    result_d  = result_q;
    status_d  = status_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_a_d = bus.op_a;
          shift_b_d = bus.op_b;
          cnt_d     = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        shift_a_d = {shift_a_q[WIDTH-2:0], 1'b0};
        shift_b_d = {shift_b_q[WIDTH-2:0], 1'b0};
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = (RESP_DELAY > 0) ? WAIT : RECV;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          cnt_d   = '0;
          state_d = RECV;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECV: begin
        rx_d = {rx_q[WIDTH-3:0], bus.res_ser};
        if (cnt_q == LAST_BIT) begin
          result_d = {rx_q, bus.res_ser};
          status_d = bus.res_status;
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.frame    = (state_q == SEND);
  assign bus.op_a_ser = (state_q == SEND) & shift_a_q[WIDTH-1];
  assign bus.op_b_ser = (state_q == SEND) & shift_b_q[WIDTH-1];
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.status   = status_q;

endmodule

// File: tb/tb_fpu_serial_host.sv
// Self-checking bench for fpu_serial_host.
// It uses a table of transactions plus random ones, a reset-abort sequence
// and a RESP_DELAY=0 instance. An FPU model drives the serial result and a
// word-level model predicts the serial bits, result, status and done timing.
module tb_fpu_serial_host;

  localparam int WIDTH = 32;
  localparam int DELAY = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  st;
    bit          keep;
    bit          glitch;
  } vec_t;

  logic clock;
  logic reset;
  int   cyc;
  int   nVectors;
  int   nMiscompares;

  logic [31:0] modelResult;
  logic [2:0]  modelStatus;
  int          lastDoneCyc;
  bit          prevKeep;

  fpu_serial_host_if #(.WIDTH(WIDTH)) bus4 ();
  fpu_serial_host_if #(.WIDTH(WIDTH)) bus0 ();

  fpu_serial_host #(.WIDTH(WIDTH), .RESP_DELAY(DELAY)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  fpu_serial_host #(.WIDTH(WIDTH), .RESP_DELAY(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle counter used to measure done spacing.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Host behaviour while the link is busy: hold start, glitch it, or stay quiet.
  task automatic busyDrive(input vec_t v);
    if (v.keep) bus4.start = 1'b1;
    else if (v.glitch) bus4.start = 1'($urandom_range(0, 1));
    else bus4.start = 1'b0;
    if (v.keep || v.glitch) begin
      bus4.op_a = $urandom;
      bus4.op_b = $urandom;
    end
  endtask

  // One full transaction on the RESP_DELAY=4 instance. It is entered and left at #1 after a rising edge.
  task automatic runTxn(input vec_t v);
    int doneCyc;
    checkBit("ready before start", bus4.ready, 1'b1);
    checkBit("done low in idle", bus4.done, 1'b0);
    bus4.start = 1'b1;
    bus4.op_a  = v.a;
    bus4.op_b  = v.b;
    @(posedge clock); #1;
    for (int i = 0; i < WIDTH; i++) begin
      busyDrive(v);
      @(negedge clock);
      checkBit($sformatf("op_a_ser bit %0d", WIDTH-1-i), bus4.op_a_ser, v.a[WIDTH-1-i]);
      checkBit($sformatf("op_b_ser bit %0d", WIDTH-1-i), bus4.op_b_ser, v.b[WIDTH-1-i]);
      checkBit("frame during send", bus4.frame, 1'b1);
      checkBit("ready during send", bus4.ready, 1'b0);
      checkVal("result held during send", bus4.result, modelResult);
      @(posedge clock); #1;
    end
    for (int i = 0; i < DELAY; i++) begin
      busyDrive(v);
      @(negedge clock);
      checkBit("frame during wait", bus4.frame, 1'b0);
      checkBit("op_a_ser during wait", bus4.op_a_ser, 1'b0);
      checkBit("done during wait", bus4.done, 1'b0);
      @(posedge clock); #1;
    end
    for (int i = 0; i < WIDTH; i++) begin
      busyDrive(v);
      bus4.res_ser    = v.res[WIDTH-1-i];
      bus4.res_status = (i == WIDTH-1) ? v.st : 3'($urandom);
      @(negedge clock);
      checkBit("frame during recv", bus4.frame, 1'b0);
      checkBit("done during recv", bus4.done, 1'b0);
      checkVal("result held during recv", bus4.result, modelResult);
      checkVal("status held during recv", 32'(bus4.status), 32'(modelStatus));
      @(posedge clock); #1;
    end
    bus4.start      = v.keep;
    bus4.res_ser    = 1'($urandom);
    bus4.res_status = 3'($urandom);
    @(negedge clock);
    doneCyc = cyc;
    checkBit("done pulse", bus4.done, 1'b1);
    modelResult = v.res;
    modelStatus = v.st;
    checkVal("result at done", bus4.result, modelResult);
    checkVal("status at done", 32'(bus4.status), 32'(modelStatus));
    if (prevKeep)
      checkVal("back-to-back done spacing", 32'(doneCyc - lastDoneCyc), 32'(2*WIDTH + DELAY + 2));
    lastDoneCyc = doneCyc;
    prevKeep    = v.keep;
    @(posedge clock); #1;
  endtask

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [31:0] w0a;
    logic [31:0] w0b;
    logic [31:0] w0r;

    nVectors     = 0;
    nMiscompares = 0;
    cyc          = 0;
    modelResult  = '0;
    modelStatus  = '0;
    lastDoneCyc  = 0;
    prevKeep     = 1'b0;

    vecs.push_back('{a: 32'hA5A5_0F0F, b: 32'h8000_0001, res: 32'h3FF0_0000, st: 3'd3, keep: 1'b0, glitch: 1'b0});
    vecs.push_back('{a: 32'h1234_5678, b: 32'h9ABC_DEF0, res: 32'h0000_0001, st: 3'd0, keep: 1'b1, glitch: 1'b0});
    vecs.push_back('{a: 32'hFFFF_FFFF, b: 32'h0000_0000, res: 32'hFFFF_FFFF, st: 3'd1, keep: 1'b0, glitch: 1'b0});
    vecs.push_back('{a: 32'h0F0F_0F0F, b: 32'hF0F0_F0F0, res: 32'hDEAD_BEEF, st: 3'd2, keep: 1'b0, glitch: 1'b1});
    for (int k = 0; k < 8; k++) begin
      v.a      = $urandom;
      v.b      = $urandom;
      v.res    = $urandom;
      v.st     = 3'($urandom_range(0, 3));
      v.keep   = (k < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      v.glitch = 1'($urandom_range(0, 1));
      vecs.push_back(v);
    end

    reset = 1'b0;
    bus4.start = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.res_ser = 1'b0; bus4.res_status = '0;
    bus0.start = 1'b0; bus0.op_a = '0; bus0.op_b = '0; bus0.res_ser = 1'b0; bus0.res_status = '0;
    @(negedge clock);
    checkBit("reset ready", bus4.ready, 1'b1);
    checkBit("reset frame", bus4.frame, 1'b0);
    checkBit("reset op_a_ser", bus4.op_a_ser, 1'b0);
    checkBit("reset done", bus4.done, 1'b0);
    checkVal("reset result", bus4.result, 32'h0);
    checkVal("reset status", 32'(bus4.status), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Zero-delay instance: the result follows directly after the operand frame.
    w0a = 32'hA5A5_0F0F;
    w0b = 32'h8000_0001;
    w0r = 32'h3FF0_0000;
    bus0.start = 1'b1; bus0.op_a = w0a; bus0.op_b = w0b;
    @(posedge clock); #1;
    bus0.start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clock);
      checkBit($sformatf("d0 op_a_ser bit %0d", WIDTH-1-i), bus0.op_a_ser, w0a[WIDTH-1-i]);
      checkBit($sformatf("d0 op_b_ser bit %0d", WIDTH-1-i), bus0.op_b_ser, w0b[WIDTH-1-i]);
      checkBit("d0 frame", bus0.frame, 1'b1);
      @(posedge clock); #1;
    end
    for (int i = 0; i < WIDTH; i++) begin
      bus0.res_ser    = w0r[WIDTH-1-i];
      bus0.res_status = (i == WIDTH-1) ? 3'd3 : 3'd0;
      @(negedge clock);
      checkBit("d0 frame during recv", bus0.frame, 1'b0);
      checkBit("d0 done during recv", bus0.done, 1'b0);
      @(posedge clock); #1;
    end
    bus0.res_status = 3'd0;
    @(negedge clock);
    checkBit("d0 done pulse", bus0.done, 1'b1);
    checkVal("d0 result", bus0.result, w0r);
    checkVal("d0 status", 32'(bus0.status), 32'd3);
    @(negedge clock);
    checkBit("d0 done single cycle", bus0.done, 1'b0);
    checkBit("d0 ready after done", bus0.ready, 1'b1);
    @(posedge clock); #1;

    // Table and random transactions on the main instance.
    foreach (vecs[k]) begin
      runTxn(vecs[k]);
      if (!vecs[k].keep) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clock);
          checkBit("ready while idle", bus4.ready, 1'b1);
          checkBit("done while idle", bus4.done, 1'b0);
          @(posedge clock); #1;
        end
      end
    end

    // Reset in the middle of SEND aborts the transaction and clears the result.
    bus4.start = 1'b1; bus4.op_a = $urandom; bus4.op_b = $urandom;
    @(posedge clock); #1;
    bus4.start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkBit("abort ready", bus4.ready, 1'b1);
    checkBit("abort frame", bus4.frame, 1'b0);
    checkBit("abort op_a_ser", bus4.op_a_ser, 1'b0);
    checkVal("abort result", bus4.result, 32'h0);
    checkVal("abort status", 32'(bus4.status), 32'h0);
    repeat (3) begin
      @(negedge clock);
      checkBit("no done in reset", bus4.done, 1'b0);
      @(posedge clock);
    end
    #1;
    reset = 1'b1;
    modelResult = '0;
    modelStatus = '0;
    prevKeep    = 1'b0;
    @(posedge clock); #1;
    v = '{a: 32'h4009_21FB, b: 32'hC000_0000, res: 32'h7FF0_0000, st: 3'd1, keep: 1'b0, glitch: 1'b1};
    runTxn(v);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/fpu_serial_host.md
# fpu_serial_host

Bit-serial host link for the FPU: accepts two 32-bit operands in parallel, shifts them MSB-first onto the FPU's serial operand lines, then deserializes the FPU's serial result and captures its 3-bit status. It is the transmitting/receiving counterpart of the FPU's serial port and sits between the parallel control logic (or testbench driver) and the FPU. Operand words follow the team float layout: sign bit 31, exponent bits 30:20, mantissa bits 19:0; this block does not interpret them.

## Interface

- WIDTH, 32, serial word length in bits; operands and result
- RESP_DELAY, 4, idle cycles between the last operand bit and the first result bit; 0 is legal

- clock  in  1  system clock (100 kHz)
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- op_a  in  WIDTH  operand A, latched on acceptance
- op_b  in  WIDTH  operand B, latched on acceptance
- ready  out  1  high in IDLE; start is ignored otherwise
- op_a_ser  out  1  serial operand A, connects to FPU op_A_in
- op_b_ser  out  1  serial operand B, connects to FPU op_B_in
- frame  out  1  high while op_a_ser/op_b_ser carry valid bits
- res_ser  in  1  serial result, from FPU data_out
- res_status  in  3  from FPU status_out (0 EXACT, 1 OVERFLOW, 2 UNDERFLOW, 3 INEXACT)
- result  out  WIDTH  last received result word
- status  out  3  status captured with result
- done  out  1  one-cycle pulse: result/status just updated

## Operation

- States: IDLE, SEND, WAIT, RECV, DONE.
- IDLE: ready=1. start=1 → load shift_a=op_a, shift_b=op_b, bit counter=0, go SEND.
- SEND: op_a_ser=shift_a[WIDTH-1], op_b_ser=shift_b[WIDTH-1], frame=1; shift left each cycle. After WIDTH cycles → WAIT (RESP_DELAY>0) or RECV (RESP_DELAY=0).
- WAIT: counter runs RESP_DELAY cycles, then → RECV.
- RECV: each edge shifts res_ser into the LSB of the receive register (first sampled bit ends in bit WIDTH-1). On the WIDTH-th sample: result ← full received word, status ← res_status sampled on that same edge, → DONE.
- DONE: done=1 for exactly one cycle, → IDLE.
- Outside SEND: op_a_ser=op_b_ser=frame=0.
- result/status hold between done pulses; partially received bits are never visible on result.
- start while ready=0 is ignored, not queued. start held high in IDLE after DONE starts a new transaction immediately.
- status is passed through verbatim; no checking or decoding.

## Timing

- Reset (asynchronous, reset=0): state=IDLE, counters=0, shift registers=0, result=0, status=0, done=0, op_a_ser=op_b_ser=frame=0, ready=1. Reset mid-transaction aborts immediately; no done, result/status cleared.
- Acceptance edge ends cycle N (start=1, ready=1).
- Cycles N+1..N+WIDTH: operand bits WIDTH-1..0, frame=1.
- Cycles N+WIDTH+1..N+WIDTH+RESP_DELAY: WAIT.
- Cycles N+WIDTH+RESP_DELAY+1..N+2·WIDTH+RESP_DELAY: res_ser sampled at each rising edge.
- Cycle N+2·WIDTH+RESP_DELAY+1: done=1, result/status valid (defaults: N+69).
- Cycle after done: ready=1. Minimum start-to-start spacing 2·WIDTH+RESP_DELAY+2 cycles (70 at defaults).
- All outputs registered or decoded directly from state; no combinational path from inputs to outputs.

## Test plan

- Reset: hold reset=0 mid-SEND for 3 cycles → ready=1, frame=0, result=0, status=0, no done; next start runs a full transaction normally.
- Serialization: op_a=0xA5A5_0F0F, op_b=0x8000_0001, start in cycle N → op_a_ser reproduces 1,0,1,0,0,1,0,1,… over N+1..N+32; op_b_ser=1 at N+1 and N+32, 0 between; frame=1 exactly those 32 cycles.
- Deserialization: bench FPU model drives 0x3FF0_0000 MSB-first from cycle N+37 with res_status=3 on the last bit → done at N+69, result=0x3FF0_0000, status=3.
- RESP_DELAY=0: same stimulus, result driven from N+33 → done at N+65, result correct.
- Back-to-back: start held high for two transactions (0x0000_0001 then 0xFFFF_FFFF results, status 0 then 1) → two done pulses 70 cycles apart, each with the correct result/status, result stable between.
- Ignored start: pulse start during SEND/WAIT/RECV with different operands → no effect on serial lines, transaction completes with the original operands.
